// File: rtl/unidad_muldiv_if.sv
// Request/result bundle for the 32-bit multiply/divide unit: operands and op
// from the issuing pipeline, status and result words back from the unit.
interface unidad_muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div0;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, div0
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, div0
  );
endinterface

// File: rtl/unidad_muldiv.sv
// Iterative 32-bit MULTU/MULT/DIVU/DIV unit, one radix-2 step per clock, fixed 33-cycle latency.
// Divide support is present only when MULDIV_DIV_EN is defined; otherwise divide requests are ignored.
//
// state | meaning
// IDLE  | waiting for start; hi/lo/div0 hold the last result
// CALC  | 32 shift-add (multiply) or restoring shift-subtract (divide) steps
// FIN   | sign fix-up, result write, done pulse
module unidad_muldiv (
  input  logic            clk,
  input  logic            rst,
  unidad_muldiv_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        load_en;
  logic        iter_en;
  logic        fin_en;
  logic        accept;

  logic [4:0]  cnt_q;
  logic [31:0] acc_hi_q;
  logic [31:0] acc_lo_q;
  logic [31:0] opnd_q;
  logic        neg_a_q;
  logic        neg_b_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        done_q;

  logic        neg_a;
  logic        neg_b;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;
  logic [63:0] prod_fix;

`ifdef MULDIV_DIV_EN
  logic        is_div_q;
  logic        b_zero_q;
  logic        div0_q;
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  assign accept = bus.start;
`else
  // Divide requests never leave IDLE in this build.
  assign accept = bus.start & ~bus.op[1];
`endif

  // Signed ops work on magnitudes; the signs are remembered for the fix-up.
  assign neg_a = bus.op[0] & bus.a[31];
  assign neg_b = bus.op[0] & bus.b[31];
  assign a_mag = neg_a ? (32'd0 - bus.a) : bus.a;
  assign b_mag = neg_b ? (32'd0 - bus.b) : bus.b;

  assign mul_sum  = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opnd_q : 32'd0)};
  assign prod_fix = (neg_a_q ^ neg_b_q) ? (64'd0 - {acc_hi_q, acc_lo_q})
                                        : {acc_hi_q, acc_lo_q};

`ifdef MULDIV_DIV_EN
  assign rem_sh   = {acc_hi_q, acc_lo_q[31]};
  assign diff     = rem_sh - {1'b0, opnd_q};
  assign quot_fix = (neg_a_q ^ neg_b_q) ? (32'd0 - acc_lo_q) : acc_lo_q;
  assign rem_fix  = neg_a_q ? (32'd0 - acc_hi_q) : acc_hi_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load_en = 1'b0;
    iter_en = 1'b0;
    fin_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          load_en = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        iter_en = 1'b1;
        if (cnt_q == 5'd31) begin
          state_d = FIN;
        end
      end
      FIN: begin
        fin_en  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= 5'd0;
      acc_hi_q <= 32'd0;
      acc_lo_q <= 32'd0;
      opnd_q   <= 32'd0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div_q <= 1'b0;
      b_zero_q <= 1'b0;
      div0_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;

      if (load_en) begin
        cnt_q    <= 5'd0;
        acc_hi_q <= 32'd0;
        neg_a_q  <= neg_a;
        neg_b_q  <= neg_b;
`ifdef MULDIV_DIV_EN
        is_div_q <= bus.op[1];
        b_zero_q <= (bus.b == 32'd0);
        if (bus.op[1]) begin
          acc_lo_q <= a_mag;
          opnd_q   <= b_mag;
        end else begin
          acc_lo_q <= b_mag;
          opnd_q   <= a_mag;
        end
`else
        acc_lo_q <= b_mag;
        opnd_q   <= a_mag;
`endif
      end

      if (iter_en) begin
        cnt_q <= cnt_q + 5'd1;
`ifdef MULDIV_DIV_EN
        if (is_div_q) begin
          // A zero divisor always subtracts, leaving an all-ones quotient and remainder |a|.
          if (!diff[32]) begin
            acc_hi_q <= diff[31:0];
            acc_lo_q <= {acc_lo_q[30:0], 1'b1};
          end else begin
            acc_hi_q <= rem_sh[31:0];
            acc_lo_q <= {acc_lo_q[30:0], 1'b0};
          end
        end else begin
          {acc_hi_q, acc_lo_q} <= {mul_sum, acc_lo_q[31:1]};
        end
`else
        {acc_hi_q, acc_lo_q} <= {mul_sum, acc_lo_q[31:1]};
`endif
      end

      if (fin_en) begin
        done_q <= 1'b1;
`ifdef MULDIV_DIV_EN
        if (is_div_q) begin
          hi_q   <= rem_fix;
          lo_q   <= b_zero_q ? 32'hFFFF_FFFF : quot_fix;
          div0_q <= b_zero_q;
        end else begin
          hi_q   <= prod_fix[63:32];
          lo_q   <= prod_fix[31:0];
          div0_q <= 1'b0;
        end
`else
        hi_q <= prod_fix[63:32];
        lo_q <= prod_fix[31:0];
`endif
      end
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
`ifdef MULDIV_DIV_EN
  assign bus.div0 = div0_q;
`else
  assign bus.div0 = 1'b0;
`endif

endmodule

// File: tb/tb_unidad_muldiv.sv
// Self-checking bench for unidad_muldiv: directed cases with literal results plus a
// randomized request stream compared every cycle against a latency/arithmetic model.
module tb_unidad_muldiv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err = 0;
  logic cmp_en = 1'b0;

  unidad_muldiv_if bus();

  unidad_muldiv dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Expected {div0, hi, lo} straight from the arithmetic definition of each op.
  function automatic logic [64:0] model_result(logic [1:0] o, logic [31:0] x, logic [31:0] y);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    logic signed [63:0] sq;
    logic signed [63:0] sr;
    logic [63:0]        p;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    case (o)
      2'b00: begin
        p = {32'd0, x} * {32'd0, y};
        return {1'b0, p};
      end
      2'b01: begin
        p = sx * sy;
        return {1'b0, p};
      end
      2'b10: begin
        if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
        return {1'b0, x % y, x / y};
      end
      default: begin
        if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
        sq = sx / sy;
        sr = sx % sy;
        return {1'b0, sr[31:0], sq[31:0]};
      end
    endcase
  endfunction

  function automatic logic allowed(logic [1:0] o);
`ifdef MULDIV_DIV_EN
    return 1'b1;
`else
    return ~o[1];
`endif
  endfunction

  int          m_rem = 0;
  logic        m_done = 1'b0;
  logic [64:0] m_res = '0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        m_div0 = 1'b0;

  // Reference: an accepted request completes 33 edges later; requests while busy are dropped.
  always @(posedge clk) begin
    if (rst) begin
      m_rem  <= 0;
      m_done <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_div0 <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_rem > 1) begin
        m_rem <= m_rem - 1;
      end else if (m_rem == 1) begin
        m_rem  <= 0;
        m_done <= 1'b1;
        m_div0 <= m_res[64];
        m_hi   <= m_res[63:32];
        m_lo   <= m_res[31:0];
      end else if (bus.start && allowed(bus.op)) begin
        m_res <= model_result(bus.op, bus.a, bus.b);
        m_rem <= 33;
      end
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", {31'd0, bus.busy}, {31'd0, (m_rem != 0)});
      check("done", {31'd0, bus.done}, {31'd0, m_done});
      check("hi",   bus.hi, m_hi);
      check("lo",   bus.lo, m_lo);
      check("div0", {31'd0, bus.div0}, {31'd0, m_div0});
    end
  end

  // Called at a negedge; returns at the negedge just after the start edge.
  task automatic launch(logic [1:0] o, logic [31:0] x, logic [31:0] y);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  task automatic wait_done(input int from, output int lat);
    lat = from;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(string name, logic [1:0] o, logic [31:0] x, logic [31:0] y);
    int lat;
    launch(o, x, y);
    wait_done(0, lat);
    check({name, "_latency"}, lat, 33);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          lat;
    int          seen;
    logic [64:0] r;

    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;

    r = model_result(2'b01, 32'hFFFF_FFFE, 32'h0000_0003);
    check("model_mult", r[31:0], 32'hFFFF_FFFA);
    r = model_result(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    check("model_div_ovf", r[31:0], 32'h8000_0000);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_div0", {31'd0, bus.div0}, 32'd0);

    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max_hi", bus.hi, 32'hFFFF_FFFE);
    check("multu_max_lo", bus.lo, 32'h0000_0001);
    check("multu_max_div0", {31'd0, bus.div0}, 32'd0);

    @(negedge clk);
    run_op("mult_neg", 2'b01, 32'hFFFF_FFFE, 32'h0000_0003);
    check("mult_neg_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult_neg_lo", bus.lo, 32'hFFFF_FFFA);

`ifdef MULDIV_DIV_EN
    @(negedge clk);
    run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'h0000_0002);
    check("div_neg_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_neg_hi", bus.hi, 32'hFFFF_FFFF);
    @(negedge clk);
    run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_lo", bus.lo, 32'h8000_0000);
    check("div_ovf_hi", bus.hi, 32'h0000_0000);
    check("div_ovf_div0", {31'd0, bus.div0}, 32'd0);
    @(negedge clk);
    run_op("divu_zero", 2'b10, 32'h0000_0064, 32'h0000_0000);
    check("divu_zero_div0", {31'd0, bus.div0}, 32'd1);
    check("divu_zero_lo", bus.lo, 32'hFFFF_FFFF);
    check("divu_zero_hi", bus.hi, 32'h0000_0064);
    @(negedge clk);
    run_op("multu_after_div0", 2'b00, 32'd2, 32'd3);
    check("multu_after_div0_div0", {31'd0, bus.div0}, 32'd0);
    check("multu_after_div0_lo", bus.lo, 32'd6);
`else
    @(negedge clk);
    launch(2'b11, 32'd100, 32'd3);
    seen = 0;
    repeat (36) begin
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) seen = 1;
      @(negedge clk);
    end
    check("nodiv_ignored", seen, 0);
    check("nodiv_lo_held", bus.lo, 32'hFFFF_FFFA);
    check("nodiv_div0", {31'd0, bus.div0}, 32'd0);
`endif

    @(negedge clk);
    launch(2'b00, 32'd5, 32'd7);
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'd1;
    bus.b     = 32'd1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(10, lat);
    check("b2b_latency", lat, 33);
    check("b2b_lo", bus.lo, 32'd35);
    check("b2b_hi", bus.hi, 32'd0);
    run_op("done_cycle_start", 2'b00, 32'd9, 32'd9);
    check("done_cycle_start_lo", bus.lo, 32'd81);

    @(negedge clk);
    launch(2'b01, 32'hFFFF_FFFF, 32'h0000_0002);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_hi", bus.hi, 32'd0);
    check("abort_lo", bus.lo, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1;
    end
    check("abort_no_done", seen, 0);

    for (int i = 0; i < 6000; i++) begin
      bus.start = ($urandom_range(0, 3) == 0);
      bus.op    = 2'($urandom_range(0, 3));
      bus.a     = pick();
      bus.b     = pick();
      rst       = ($urandom_range(0, 599) == 0);
      @(negedge clk);
    end
    bus.start = 1'b0;
    rst = 1'b0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
